// File: rtl/sonic_eth_xgmii_pkg.sv
// Shared XGMII character codes, link fault status codes, forced-word
// constants and the fault responder state type.
package sonic_eth_xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;

    localparam logic [1:0] LF_OK     = 2'b00;
    localparam logic [1:0] LF_LOCAL  = 2'b01;
    localparam logic [1:0] LF_REMOTE = 2'b10;
    localparam logic [1:0] LF_RSVD   = 2'b11;

    // Remote Fault ordered set in both columns: Seq in lanes 0/4, 0x02 in lanes 3/7.
    localparam logic [63:0] RF_DATA   = {8'h02, 8'h00, 8'h00, XGMII_SEQ,
                                         8'h02, 8'h00, 8'h00, XGMII_SEQ};
    localparam logic [7:0]  RF_CTRL   = 8'h11;
    localparam logic [63:0] IDLE_DATA = {8{XGMII_IDLE}};
    localparam logic [7:0]  IDLE_CTRL = 8'hFF;

    typedef enum logic [1:0] {
        ST_PASS,
        ST_DRAIN,
        ST_FORCE,
        ST_FLUSH
    } lf_state_t;

endpackage

// File: rtl/sonic_eth_lf_status_filter.sv
// Link fault status debounce.
// A status value is accepted as filt_status once STABLE_CYCLES consecutive
// valid beats carried it. Reserved code 11 and non-valid cycles leave the
// run length untouched.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   status_data    raw 2-bit status from the RX link fault adapter
//   status_valid   beat qualifier
//   filt_status    debounced status
module sonic_eth_lf_status_filter
    import sonic_eth_xgmii_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] status_data,
    input  logic       status_valid,
    output logic [1:0] filt_status
);

    logic [1:0] last_status;
    logic [7:0] run_cnt;
    logic [7:0] run_cnt_n;
    logic       beat;

    assign beat = status_valid && (status_data != LF_RSVD);

    // The run length is capped at STABLE_CYCLES: beyond that only "still stable" matters.
    always_comb begin
        if (status_data == last_status && run_cnt != 8'd0)
            run_cnt_n = (run_cnt >= 8'(STABLE_CYCLES)) ? run_cnt : run_cnt + 8'd1;
        else
            run_cnt_n = 8'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_status <= LF_OK;
            run_cnt     <= 8'd0;
            filt_status <= LF_OK;
        end else if (beat) begin
            last_status <= status_data;
            run_cnt     <= run_cnt_n;
            if (run_cnt_n >= 8'(STABLE_CYCLES))
                filt_status <= status_data;
        end
    end

endmodule

// File: rtl/sonic_eth_10g_tx_link_fault_gen.sv
// TX Reconciliation Sublayer fault responder.
// Local fault -> Remote Fault ordered sets, remote fault -> Idle, no fault ->
// MAC traffic passes. Frames are never cut: an in-flight frame drains before
// forcing starts, and a frame cut by forcing is flushed to Idle before
// passthrough resumes. One register stage from xgmii_in to xgmii_out.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   lf_status_data/valid/ready      link fault status stream (ready tied 1)
//   xgmii_in_data/ctrl              MAC TX XGMII word (2 columns)
//   xgmii_out_data/ctrl             registered XGMII word to the PCS
//   fault_active                    output word is forced
//   frames_dropped                  saturating count of discarded frames
module sonic_eth_10g_tx_link_fault_gen
    import sonic_eth_xgmii_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       lf_status_data,
    input  logic             lf_status_valid,
    output logic             lf_status_ready,
    input  logic [63:0]      xgmii_in_data,
    input  logic [7:0]       xgmii_in_ctrl,
    output logic [63:0]      xgmii_out_data,
    output logic [7:0]       xgmii_out_ctrl,
    output logic             fault_active,
    output logic [CNT_W-1:0] frames_dropped
);

    logic [1:0]       filt_status;
    lf_state_t        state, state_n;
    logic             in_frame;
    logic [7:0]       term;
    logic             start0, start4, term_any, term_lo, term_hi;
    logic             frame_open, late_start;
    logic [63:0]      out_data_n;
    logic [7:0]       out_ctrl_n;
    logic             forced;
    logic [1:0]       drop_inc;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] frames_dropped_n;

    assign lf_status_ready = 1'b1;

    sonic_eth_lf_status_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_status_filter (
        .clk          (clk),
        .reset_n      (reset_n),
        .status_data  (lf_status_data),
        .status_valid (lf_status_valid),
        .filt_status  (filt_status)
    );

    always_comb begin
        for (int l = 0; l < 8; l++)
            term[l] = xgmii_in_ctrl[l] && (xgmii_in_data[8*l +: 8] == XGMII_TERM);
    end

    assign start0   = xgmii_in_ctrl[0] && (xgmii_in_data[7:0]   == XGMII_START);
    assign start4   = xgmii_in_ctrl[4] && (xgmii_in_data[39:32] == XGMII_START);
    assign term_any = |term;
    assign term_lo  = |term[3:0];
    assign term_hi  = |term[7:5];

    // Frame state after this word, walking lanes in order: a lane-4 Start
    // opens a frame unless its own Terminate follows in lanes 5-7.
    assign frame_open = start4 ? !term_hi :
                        start0 ? !term_any :
                                 (in_frame && !term_any);
    // A new frame begins in the second column of a word that ended the previous one.
    assign late_start = start4 && term_lo;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_n    = state;
        out_data_n = xgmii_in_data;
        out_ctrl_n = xgmii_in_ctrl;
        forced     = 1'b0;
        drop_inc   = 2'd0;
        case (state)
            ST_PASS: begin
                if (filt_status != LF_OK)
                    state_n = frame_open ? ST_DRAIN : ST_FORCE;
            end
            ST_DRAIN: begin
                if (late_start) begin
                    out_data_n[63:32] = {4{XGMII_IDLE}};
                    out_ctrl_n[7:4]   = 4'hF;
                    drop_inc          = 2'd1;
                end
                // Always pass through FORCE, even if the fault has already cleared.
                if (term_any)
                    state_n = ST_FORCE;
            end
            ST_FORCE: begin
                forced     = 1'b1;
                out_data_n = (filt_status == LF_LOCAL) ? RF_DATA : IDLE_DATA;
                out_ctrl_n = (filt_status == LF_LOCAL) ? RF_CTRL : IDLE_CTRL;
                drop_inc   = {1'b0, start0} + {1'b0, start4};
                if (filt_status == LF_OK)
                    state_n = frame_open ? ST_FLUSH : ST_PASS;
            end
            ST_FLUSH: begin
                forced     = 1'b1;
                out_data_n = IDLE_DATA;
                out_ctrl_n = IDLE_CTRL;
                if (late_start)
                    drop_inc = 2'd1;
                if (term_any)
                    state_n = ST_PASS;
            end
            default: state_n = ST_PASS;
        endcase
    end

    assign drop_sum         = {1'b0, frames_dropped} + (CNT_W+1)'(drop_inc);
    assign frames_dropped_n = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_PASS;
            in_frame       <= 1'b0;
            xgmii_out_data <= IDLE_DATA;
            xgmii_out_ctrl <= IDLE_CTRL;
            fault_active   <= 1'b0;
            frames_dropped <= '0;
        end else begin
            state          <= state_n;
            in_frame       <= frame_open;
            xgmii_out_data <= out_data_n;
            xgmii_out_ctrl <= out_ctrl_n;
            fault_active   <= forced;
            frames_dropped <= frames_dropped_n;
        end
    end

endmodule
